// File: rtl/dff_force_sequencer_pkg.sv
// Shared types and default sizes for the dff_force_sequencer block.
package dff_force_pkg;
  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    FORCE = 2'd2
  } state_t;
endpackage

// File: rtl/dff_force_sequencer_force_cnt.sv
// Loadable down-counter shared by the delay and hold phases.
// Load has priority over enable; the count parks at zero instead of wrapping.
module force_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: load, else decrement toward zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dff_force_sequencer.sv
// dff_force_sequencer: WIDTH-bit D register whose output Q can be overridden
// with a latched value for a programmed window (delay, then hold cycles).
// Optional macro FORCE_REARM_EN: when defined, each window re-arms itself
// with the latched delay/hold, giving a periodic force pattern until abort.
// Output flops (Q, Qbar, forcing, done) lag the FSM state by one edge, so a
// window occupying FORCE for hold cycles is visible on Q one edge later.
module dff_force_sequencer
  import dff_force_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] hold,
  input  logic [WIDTH-1:0] force_val,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             busy,
  output logic             forcing,
  output logic             done
);

  state_t           state_q;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] hold_q;
  logic [WIDTH-1:0] fval_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] qbar_q;
  logic             forcing_q;
  logic             done_q;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             cnt_one;
  logic             cnt_last;

  logic             accept;
  logic             force_win;
  logic             win_end;
  logic [WIDTH-1:0] q_d;

  force_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  // Zero is treated like one so a phase can never stall on an empty count.
  assign cnt_last  = cnt_one | cnt_zero;
  assign accept    = (state_q == IDLE) && start && !abort;
  assign force_win = (state_q == FORCE) && !abort;
  assign win_end   = !abort &&
                     (((state_q == FORCE) && cnt_last) ||
                      ((state_q == DELAY) && (hold_q == '0)));
  // Q holds the live D sample whenever it is not overridden.
  assign q_d       = force_win ? fval_q : D;

  // Counter control: load at phase entry, otherwise count down.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          cnt_val  = (delay == '0) ? hold : delay;
        end
      end
      DELAY: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = hold_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FORCE: begin
        if (cnt_last) begin
`ifdef FORCE_REARM_EN
          cnt_load = 1'b1;
          cnt_val  = (delay_q == '0) ? hold_q : delay_q;
`endif
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered Q/Qbar/forcing/done.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      hold_q    <= '0;
      fval_q    <= '0;
      q_q       <= '0;
      qbar_q    <= '1;
      forcing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      q_q       <= q_d;
      qbar_q    <= ~q_d;
      forcing_q <= force_win;
      done_q    <= win_end;
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              delay_q <= delay;
              hold_q  <= hold;
              fval_q  <= force_val;
              // A zero-length window spends one cycle in DELAY to report done.
              if (hold == '0)       state_q <= DELAY;
              else if (delay == '0) state_q <= FORCE;
              else                  state_q <= DELAY;
            end
          end
          DELAY: begin
            if (hold_q == '0)  state_q <= IDLE;
            else if (cnt_last) state_q <= FORCE;
          end
          FORCE: begin
            if (cnt_last) begin
`ifdef FORCE_REARM_EN
              state_q <= (delay_q == '0) ? FORCE : DELAY;
`else
              state_q <= IDLE;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Q       = q_q;
  assign Qbar    = qbar_q;
  assign busy    = (state_q != IDLE);
  assign forcing = forcing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dff_force_sequencer.sv
// Directed bench for dff_force_sequencer (WIDTH=4, CNT_W=8).
module tb_dff_force_sequencer;

  logic       CLK;
  logic       RESET;
  logic [3:0] D;
  logic       start;
  logic [7:0] delay;
  logic [7:0] hold;
  logic [3:0] force_val;
  logic       abort;
  logic [3:0] Q;
  logic [3:0] Qbar;
  logic       busy;
  logic       forcing;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       s;
    logic       a;
    logic [7:0] dl;
    logic [7:0] hd;
    logic [3:0] fv;
    logic [3:0] d;
    logic [3:0] eq;
    logic       ef;
    logic       ed;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  dff_force_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .D         (D),
    .start     (start),
    .delay     (delay),
    .hold      (hold),
    .force_val (force_val),
    .abort     (abort),
    .Q         (Q),
    .Qbar      (Qbar),
    .busy      (busy),
    .forcing   (forcing),
    .done      (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void add(input logic s, input logic a, input int dl, input int hd,
                              input int fv, input int d, input int eq,
                              input logic ef, input logic ed, input logic eb);
    vec_t v;
    v.s = s; v.a = a; v.dl = 8'(dl); v.hd = 8'(hd); v.fv = 4'(fv);
    v.d = 4'(d); v.eq = 4'(eq); v.ef = ef; v.ed = ed; v.eb = eb;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(input int idx, input logic [3:0] eq, input logic ef,
                         input logic ed, input logic eb);
    logic [3:0] nq;
    nq = ~eq;
    chk("Q", idx, {4'h0, Q}, {4'h0, eq});
    chk("Qbar", idx, {4'h0, Qbar}, {4'h0, nq});
    chk("forcing", idx, {7'h0, forcing}, {7'h0, ef});
    chk("done", idx, {7'h0, done}, {7'h0, ed});
    chk("busy", idx, {7'h0, busy}, {7'h0, eb});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input int dl, input int hd,
                       input int fv, input int d);
    start = s; abort = a; delay = 8'(dl); hold = 8'(hd);
    force_val = 4'(fv); D = 4'(d);
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b1, 1'b0, 0, 3, 9, 5);

    // Reset held two cycles; start during reset must be ignored.
    step();
    chk_out(900, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out(901, 4'h0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;

`ifdef FORCE_REARM_EN
    // delay=3, hold=2 repeats 2 cycles on, 3 off; done every 5 cycles.
    drive(1'b1, 1'b0, 3, 2, 15, 0);
    step();
    chk_out(1000, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 20; k++) begin
      logic ef;
      logic ed;
      drive(1'b0, 1'b0, 0, 0, 0, 0);
      step();
      ef = (k >= 4) && (((k - 4) % 5) < 2);
      ed = (k >= 5) && (((k - 5) % 5) == 0);
      chk_out(1000 + k, ef ? 4'hF : 4'h0, ef, ed, 1'b1);
    end
    drive(1'b0, 1'b1, 0, 0, 0, 6);
    step();
    chk_out(1100, 4'h6, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 7);
    step();
    chk_out(1101, 4'h7, 1'b0, 1'b0, 1'b0);
`else
    //   s     a     dl  hd  fv  D   eQ  ef    ed    eb
    // basic window: delay=4 hold=5, later input changes ignored
    add(1'b0, 1'b0, 0,  0,  0,  3,  3,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 0,  0,  0,  5,  5,  1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4,  5,  10, 6,  6,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  7,  7,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  8,  8,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  9,  9,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  1,  1,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  2,  10, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 0,  1,  0,  3,  10, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  4,  10, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  5,  10, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  1,  0,  6,  10, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 0,  1,  0,  12, 12, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 0,  1,  0,  14, 14, 1'b0, 1'b0, 1'b0);
    // delay=0 hold=3
    add(1'b1, 1'b0, 0,  3,  5,  0,  0,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  3,  5,  1,  5,  1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  3,  5,  2,  5,  1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0,  3,  5,  3,  5,  1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 0,  3,  5,  4,  4,  1'b0, 1'b0, 1'b0);
    // hold=0 delay=7: one busy cycle then done, never forcing
    add(1'b1, 1'b0, 7,  0,  15, 6,  6,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 7,  0,  15, 7,  7,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 7,  0,  15, 8,  8,  1'b0, 1'b0, 1'b0);
    // abort on 4th forced cycle, then restart one cycle later
    add(1'b1, 1'b0, 2,  10, 9,  1,  1,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2,  10, 9,  2,  2,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2,  10, 9,  3,  3,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2,  10, 9,  4,  9,  1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2,  10, 9,  5,  9,  1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2,  10, 9,  6,  9,  1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2,  10, 9,  7,  9,  1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 2,  10, 9,  8,  8,  1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1,  1,  3,  10, 10, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1,  1,  3,  11, 11, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1,  1,  3,  12, 3,  1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1,  1,  3,  13, 13, 1'b0, 1'b0, 1'b0);
    // abort beats start in IDLE; abort during DELAY
    add(1'b1, 1'b1, 0,  2,  6,  14, 14, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 0,  2,  6,  15, 15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3,  2,  6,  0,  0,  1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 3,  2,  6,  1,  1,  1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3,  2,  6,  2,  2,  1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].a, int'(tbl[i].dl), int'(tbl[i].hd),
            int'(tbl[i].fv), int'(tbl[i].d));
      step();
      chk_out(i, tbl[i].eq, tbl[i].ef, tbl[i].ed, tbl[i].eb);
    end

    // Reset during DELAY, then a normal window.
    drive(1'b1, 1'b0, 5, 2, 10, 1);
    step();
    chk_out(200, 4'h1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 5, 2, 10, 2);
    step();
    chk_out(201, 4'h2, 1'b0, 1'b0, 1'b1);
    RESET = 1'b1;
    drive(1'b1, 1'b0, 5, 2, 10, 3);
    step();
    chk_out(202, 4'h0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    drive(1'b0, 1'b0, 5, 2, 10, 4);
    step();
    chk_out(203, 4'h4, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 1, 5, 6);
    step();
    chk_out(204, 4'h6, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 1, 5, 7);
    step();
    chk_out(205, 4'h5, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 0, 1, 5, 8);
    step();
    chk_out(206, 4'h8, 1'b0, 1'b0, 1'b0);

    // Reset during FORCE drops forcing on that edge.
    drive(1'b1, 1'b0, 0, 4, 12, 1);
    step();
    chk_out(210, 4'h1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 4, 12, 2);
    step();
    chk_out(211, 4'hC, 1'b1, 1'b0, 1'b1);
    RESET = 1'b1;
    drive(1'b0, 1'b0, 0, 4, 12, 3);
    step();
    chk_out(212, 4'h0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    drive(1'b0, 1'b0, 0, 4, 12, 9);
    step();
    chk_out(213, 4'h9, 1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
